// File: rtl/tsp_pkg.sv
// Shared transport-stream constants, PID field layout and FSM encodings
// used by multi_pid_monitor and pid_slot_match.
package tsp_pkg;

  localparam int PACK_BYTE_SIZE = 188;
  localparam int PACK_WORD_SIZE = 47;
  localparam logic [7:0] SYNC_BYTE = 8'h47;

  localparam int PID_LSB        = 0;
  localparam int PID_WIDTH      = 13;
  localparam int PID_EN_BIT     = 16;
  localparam int SLOT_IDX_WIDTH = 4;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_HDR  = 2'd1,
    CAP_BODY = 2'd2
  } cap_state_e;

  typedef enum logic [1:0] {
    PUMP_IDLE  = 2'd0,
    PUMP_WAIT  = 2'd1,
    PUMP_DRAIN = 2'd2,
    PUMP_ACK   = 2'd3
  } pump_state_e;

  function automatic logic [PID_WIDTH-1:0] hdr_pid(input logic [7:0] b1, input logic [7:0] b2);
    return {b1[4:0], b2};
  endfunction

endpackage

// File: rtl/pid_slot_match.sv
// PID filter slot register file with parallel lowest-index-first compare
// and a registered readback port.
module pid_slot_match
  import tsp_pkg::*;
#(
  parameter int PID_SLOTS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [31:0]               index,
  input  logic [PID_WIDTH-1:0]      wr_pid,
  input  logic                      wr_pid_en,
  input  logic [PID_WIDTH-1:0]      cmp_pid,
  output logic                      hit,
  output logic [SLOT_IDX_WIDTH-1:0] hit_slot,
  output logic [31:0]               rd_word
);

  logic [PID_WIDTH-1:0]      slot_pid_r [PID_SLOTS];
  logic [PID_SLOTS-1:0]      slot_en_r;
  logic [31:0]               rd_word_r;
  logic [31:0]               rd_word_s;
  logic                      hit_s;
  logic [SLOT_IDX_WIDTH-1:0] hit_slot_s;

  // Slot writes and readback register; out-of-range indices touch nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PID_SLOTS; i++) begin
        slot_pid_r[i] <= {PID_WIDTH{1'b0}};
      end
      slot_en_r <= {PID_SLOTS{1'b0}};
      rd_word_r <= 32'd0;
    end else begin
      for (int i = 0; i < PID_SLOTS; i++) begin
        if (wr_en && (index == 32'(i))) begin
          slot_pid_r[i] <= wr_pid;
          slot_en_r[i]  <= wr_pid_en;
        end
      end
      rd_word_r <= rd_word_s;
    end
  end

  // Walk from the top slot down so the lowest matching index wins.
  always_comb begin
    hit_s      = 1'b0;
    hit_slot_s = {SLOT_IDX_WIDTH{1'b0}};
    for (int i = PID_SLOTS - 1; i >= 0; i--) begin
      if (slot_en_r[i] && (slot_pid_r[i] == cmp_pid)) begin
        hit_s      = 1'b1;
        hit_slot_s = SLOT_IDX_WIDTH'(i);
      end else begin
        hit_s      = hit_s;
        hit_slot_s = hit_slot_s;
      end
    end
  end

  // Readback mux, zero when the index is beyond the slot count.
  always_comb begin
    rd_word_s = 32'd0;
    for (int i = 0; i < PID_SLOTS; i++) begin
      if (index == 32'(i)) begin
        rd_word_s = {15'd0, slot_en_r[i], 3'd0, slot_pid_r[i]};
      end else begin
        rd_word_s = rd_word_s;
      end
    end
  end

  assign hit      = hit_s;
  assign hit_slot = hit_slot_s;
  assign rd_word  = rd_word_r;

endmodule

// File: rtl/multi_pid_monitor.sv
// Multi-slot PID filter: captures one matching TS packet into a 47-word buffer
// and drains it on request. Optional drop counter: MULTI_PID_MONITOR_DROP_CNT_EN.
module multi_pid_monitor
  import tsp_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int PID_SLOTS          = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          match_enable,
  input  logic                          update_pid_request,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] pid_index,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] pid,
  output logic [C_S_AXI_DATA_WIDTH-1:0] out_pid,
  input  logic                          pump_data_request,
  output logic                          pump_data_request_ready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] out_data,
  output logic [C_S_AXI_DATA_WIDTH-1:0] out_data_index,
  output logic [C_S_AXI_DATA_WIDTH-1:0] out_slot,
  output logic [C_S_AXI_DATA_WIDTH-1:0] matched_count,
  input  logic [7:0]                    mpeg_data,
  input  logic                          mpeg_valid,
  input  logic                          mpeg_sync
`ifdef MULTI_PID_MONITOR_DROP_CNT_EN
  ,
  output logic [C_S_AXI_DATA_WIDTH-1:0] drop_count
`endif
);

  cap_state_e  cap_state_r, cap_next_s;
  pump_state_e pump_state_r, pump_next_s;

  logic [7:0]                    byte_cnt_r, byte1_r, wr_idx_s;
  logic                          store_r, hit_r, men_r, full_r, ready_r, wr_en_s;
  logic [SLOT_IDX_WIDTH-1:0]     slot_r, hit_slot_s;
  logic                          hit_s, is_sync_s, at_b2_s, at_last_s, accept_s, drop_s, drain_last_s;
  logic [PID_WIDTH-1:0]          cmp_pid_s;
  logic [5:0]                    word_idx_r;
  logic [31:0]                   buf_r [PACK_WORD_SIZE];
  logic [C_S_AXI_DATA_WIDTH-1:0] matched_count_r, out_slot_r, out_data_r, out_idx_r;
  logic                          unused_pid_s;

  assign unused_pid_s = ^{pid[31:17], pid[15:13]};

  pid_slot_match #(.PID_SLOTS(PID_SLOTS)) u_slots (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (update_pid_request),
    .index     (pid_index),
    .wr_pid    (pid[PID_LSB +: PID_WIDTH]),
    .wr_pid_en (pid[PID_EN_BIT]),
    .cmp_pid   (cmp_pid_s),
    .hit       (hit_s),
    .hit_slot  (hit_slot_s),
    .rd_word   (out_pid)
  );

  assign is_sync_s    = mpeg_valid && mpeg_sync && (mpeg_data == SYNC_BYTE);
  assign cmp_pid_s    = hdr_pid(byte1_r, mpeg_data);
  assign at_b2_s      = mpeg_valid && !is_sync_s && (cap_state_r == CAP_HDR) && (byte_cnt_r == 8'd2);
  assign at_last_s    = mpeg_valid && !is_sync_s && (cap_state_r == CAP_BODY) &&
                        (byte_cnt_r == 8'(PACK_BYTE_SIZE - 1));
  assign accept_s     = at_last_s && hit_r && men_r && store_r;
  assign drop_s       = at_last_s && hit_r && men_r && !store_r;
  assign drain_last_s = (pump_state_r == PUMP_DRAIN) && (word_idx_r == 6'(PACK_WORD_SIZE - 1));

  // Capture next state; a sync byte restarts the packet from any state.
  always_comb begin
    cap_next_s = cap_state_r;
    if (!mpeg_valid) begin
      cap_next_s = cap_state_r;
    end else if (is_sync_s) begin
      cap_next_s = CAP_HDR;
    end else begin
      case (cap_state_r)
        CAP_IDLE: cap_next_s = CAP_IDLE;
        CAP_HDR:  cap_next_s = (byte_cnt_r == 8'd2) ? CAP_BODY : CAP_HDR;
        CAP_BODY: cap_next_s = (byte_cnt_r == 8'(PACK_BYTE_SIZE - 1)) ? CAP_IDLE : CAP_BODY;
        default:  cap_next_s = CAP_IDLE;
      endcase
    end
  end

  // Buffer write strobe; the store decision is taken once, at the sync byte.
  always_comb begin
    wr_en_s  = 1'b0;
    wr_idx_s = byte_cnt_r;
    if (is_sync_s) begin
      wr_en_s  = !full_r;
      wr_idx_s = 8'd0;
    end else if (mpeg_valid && (cap_state_r != CAP_IDLE)) begin
      wr_en_s  = store_r;
      wr_idx_s = byte_cnt_r;
    end else begin
      wr_en_s  = 1'b0;
      wr_idx_s = byte_cnt_r;
    end
  end

  // Capture state, header fields, latched match and acceptance bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_state_r     <= CAP_IDLE;
      byte_cnt_r      <= 8'd0;
      byte1_r         <= 8'd0;
      store_r         <= 1'b0;
      hit_r           <= 1'b0;
      men_r           <= 1'b0;
      slot_r          <= {SLOT_IDX_WIDTH{1'b0}};
      matched_count_r <= 32'd0;
      out_slot_r      <= 32'd0;
    end else begin
      cap_state_r <= cap_next_s;
      if (is_sync_s) begin
        byte_cnt_r <= 8'd1;
        store_r    <= !full_r;
        hit_r      <= 1'b0;
        men_r      <= 1'b0;
      end else if (mpeg_valid && (cap_state_r != CAP_IDLE)) begin
        byte_cnt_r <= byte_cnt_r + 8'd1;
      end
      if (mpeg_valid && !is_sync_s && (cap_state_r == CAP_HDR) && (byte_cnt_r == 8'd1)) begin
        byte1_r <= mpeg_data;
      end
      if (at_b2_s) begin
        hit_r  <= hit_s;
        slot_r <= hit_slot_s;
        men_r  <= match_enable;
      end
      if (accept_s) begin
        matched_count_r <= matched_count_r + 32'd1;
        out_slot_r      <= 32'(slot_r);
      end
    end
  end

  // Packet buffer storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_r[wr_idx_s[7:2]][{wr_idx_s[1:0], 3'b000} +: 8] <= mpeg_data;
    end
  end

  // Buffer-full flag: set by an accepted packet, released as the drain ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= 1'b0;
    end else if (accept_s) begin
      full_r <= 1'b1;
    end else if (drain_last_s) begin
      full_r <= 1'b0;
    end
  end

  // Pump next state.
  always_comb begin
    pump_next_s = pump_state_r;
    case (pump_state_r)
      PUMP_IDLE:  pump_next_s = pump_data_request ? PUMP_WAIT : PUMP_IDLE;
      PUMP_WAIT:  pump_next_s = full_r ? PUMP_DRAIN : PUMP_WAIT;
      PUMP_DRAIN: pump_next_s = drain_last_s ? PUMP_ACK : PUMP_DRAIN;
      PUMP_ACK:   pump_next_s = PUMP_IDLE;
      default:    pump_next_s = PUMP_IDLE;
    endcase
  end

  // Pump state and drain datapath; ready rises with the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pump_state_r <= PUMP_IDLE;
      word_idx_r   <= 6'd0;
      out_data_r   <= 32'd0;
      out_idx_r    <= 32'd0;
      ready_r      <= 1'b0;
    end else begin
      pump_state_r <= pump_next_s;
      ready_r      <= drain_last_s;
      if (pump_state_r == PUMP_WAIT) begin
        word_idx_r <= 6'd0;
      end else if (pump_state_r == PUMP_DRAIN) begin
        word_idx_r <= word_idx_r + 6'd1;
        out_data_r <= buf_r[word_idx_r];
        out_idx_r  <= 32'(word_idx_r);
      end
    end
  end

`ifdef MULTI_PID_MONITOR_DROP_CNT_EN
  logic [C_S_AXI_DATA_WIDTH-1:0] drop_count_r;

  // Matched packets lost because the buffer was still occupied at their sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_r <= 32'd0;
    end else if (drop_s) begin
      drop_count_r <= drop_count_r + 32'd1;
    end
  end

  assign drop_count = drop_count_r;
`else
  logic unused_drop_s;
  assign unused_drop_s = drop_s;
`endif

  assign matched_count           = matched_count_r;
  assign out_slot                = out_slot_r;
  assign out_data                = out_data_r;
  assign out_data_index          = out_idx_r;
  assign pump_data_request_ready = ready_r;

endmodule

// File: doc/multi_pid_monitor.md
MULTI_PID_MONITOR -- requirements
Module: multi_pid_monitor

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI word width; only 32 is supported.
REQ-002 SHALL have parameter PID_SLOTS, default 4, number of PID filter slots, range 1..16.
REQ-003 SHALL have ports clk in 1, single clock for all logic; rst_n in 1, reset, asynchronous and active-low.
REQ-004 SHALL have ports match_enable in 1, global capture enable; update_pid_request in 1, one-cycle slot write strobe.
REQ-005 SHALL have ports pid_index in 32, slot select for write and readback; pid in 32, slot word with PID at [12:0] and enable at [16].
REQ-006 SHALL have port out_pid out 32, readback of slot pid_index: {15'b0, en, 3'b0, pid}, all zeros when pid_index >= PID_SLOTS.
REQ-007 SHALL have ports pump_data_request in 1, start a drain; pump_data_request_ready out 1, one-cycle drain-done pulse.
REQ-008 SHALL have ports out_data out 32, drained word; out_data_index out 32, word index 0..46; out_slot out 32, matching slot number of the drained packet.
REQ-009 SHALL have ports matched_count out 32, count of accepted packets; mpeg_data in 8, mpeg_valid in 1, mpeg_sync in 1, TS byte stream qualified by mpeg_valid in the clk domain.

Function
REQ-010 SHALL ignore stream inputs on cycles with mpeg_valid=0; bytes are counted only on valid cycles.
REQ-011 SHALL run capture FSM states IDLE, HDR, BODY: IDLE->HDR when a valid byte arrives with mpeg_sync=1 and mpeg_data=8'h47.
REQ-012 SHALL store every packet byte n (0..187) into buffer word n/4, lane n%4 (byte 0 at [7:0]), on every valid byte from sync onward.
REQ-013 SHALL form PID as {byte1[4:0], byte2} and compare it against all slots in parallel when byte 2 arrives; the match is the lowest-index slot with en=1 and equal PID.
REQ-014 SHALL move HDR->BODY after byte 2 with the match result latched, and BODY->IDLE after byte 187.
REQ-015 SHALL mark the packet accepted at byte 187 only if it matched, match_enable=1 at byte 2, and the buffer was free at sync; accepted sets buffer full, increments matched_count (wrapping at 2^32), and latches out_slot.
REQ-016 SHALL abort the packet when a sync byte 0x47 arrives before byte 187: no acceptance, and the new byte is treated as byte 0 of a new packet.
REQ-017 SHALL NOT write the buffer while it is full; packets arriving with the buffer full are counted as drops (REQ-024), not stored.
REQ-018 SHALL run pump FSM states IDLE, WAIT, DRAIN, ACK: IDLE->WAIT on pump_data_request=1; WAIT->DRAIN when the buffer is full.
REQ-019 SHALL in DRAIN present one word per cycle, out_data=buffer[i] and out_data_index=i for i=0..46; out_data and out_data_index hold their values after the last word.
REQ-020 SHALL in ACK pulse pump_data_request_ready high for exactly one cycle, free the buffer in that same cycle, and return to IDLE.
REQ-021 SHALL give a slot write priority over capture: the slot update takes effect on the next cycle, and a packet already past byte 2 keeps its latched match.

Reset
REQ-022 SHALL asynchronously on rst_n=0 clear all slots, both FSMs to IDLE, the buffer-full flag, matched_count, out_data, out_data_index, out_slot, pump_data_request_ready, and the drop count to 0; buffer contents are not reset.
REQ-023 SHALL on reset mid-packet or mid-drain discard all partial state; the first packet after release needs a fresh sync.

Configuration
REQ-024 SHALL with MULTI_PID_MONITOR_DROP_CNT_EN defined add output drop_count (32, reset 0, wrapping), incremented per matched packet lost to a full buffer; without the macro, the port and its counter are absent and behaviour is otherwise identical.

Structure
REQ-025 SHALL place shared constants in package tsp_pkg: PACK_BYTE_SIZE=188, PACK_WORD_SIZE=47, SYNC_BYTE=8'h47, PID field offsets/widths, and FSM state enums.
REQ-026 SHALL implement the parallel slot register file, lowest-index priority compare and readback mux in sub-module pid_slot_match.

Verification
REQ-027 SHALL test: slot 2 set to PID 0x0100 en=1 plus one packet with PID 0x0100 -> matched_count=1, out_slot=2, 47 words drained in byte order, one ready pulse.
REQ-028 SHALL test: slots 1 and 3 both set to PID 0x1FFF -> out_slot=1.
REQ-029 SHALL test: sync at byte 100 of a matching packet -> no acceptance; the next full matching packet is accepted with matched_count=1.
REQ-030 SHALL test: two matching packets and no pump request -> the second is dropped (drop_count=1 if enabled) and buffer contents equal the first packet.
REQ-031 SHALL test: mpeg_valid toggling 50% during a packet -> data is identical to the contiguous case; match_enable=0 -> matched_count stays 0.
REQ-032 SHALL test: rst_n asserted during DRAIN at word 20 -> all outputs are 0 immediately and no ready pulse occurs.
